am_mult_share_sched: RTL and testbench



---
 rtl/am_sched_pkg.sv | 27 ++
 rtl/am8x8_l4_core.sv | 43 ++++
 rtl/am_mult_share_sched.sv | 139 +++++++++++++
 tb/tb_am_mult_share_sched.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/am_sched_pkg.sv
// Shared widths, pipeline entry types and the round-robin index helper for
// the shared 8x8 multiplier scheduler.
package am_sched_pkg;

    localparam int OPW     = 8;
    localparam int PRODW   = 16;
    localparam int IDW_MAX = 3;

    typedef struct packed {
        logic [IDW_MAX-1:0] id;
        logic [OPW-1:0]     x;
        logic [OPW-1:0]     y;
        logic               approx;
    } s1_entry_t;

    typedef struct packed {
        logic [IDW_MAX-1:0] id;
        logic [PRODW-1:0]   z;
        logic               approx;
    } s2_entry_t;

    // Candidate index 'step' positions after 'base' in a ring of n requesters.
    function automatic int rr_index(input int base, input int step, input int n);
        return (base + step) % n;
    endfunction

endpackage

// File: rtl/am8x8_l4_core.sv
// l4 approximate 8x8 unsigned multiplier: exact upper-nibble partial products,
// compressed low-nibble partial products feeding bits 7..10.
module am8x8_l4_core (
    input  logic [7:0]  x,
    input  logic [7:0]  y,
    output logic [15:0] z
);

    logic [7:0]  pp [4];
    logic [15:0] hi_part;
    logic [2:0]  c7;
    logic [1:0]  c8;
    logic [1:0]  c9;
    logic        c10;

    // pp[i][j] = x[i] & y[j] for the four low bits of x
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_pp
            assign pp[gi] = y & {8{x[gi]}};
        end
    endgenerate

    assign hi_part = 16'(y) * {12'b0, x[7:4]};

    assign c7  = {2'b0, pp[0][6] | pp[1][5]}
               + {2'b0, pp[0][7] | pp[1][6]}
               + {2'b0, pp[2][4] | pp[3][3]}
               + {2'b0, pp[2][5] ^ pp[3][4]};
    assign c8  = {1'b0, pp[1][7]}
               + {1'b0, pp[2][5] & pp[3][4]}
               + {1'b0, pp[2][6] ^ pp[3][5]};
    assign c9  = {1'b0, pp[2][6] & pp[3][5]}
               + {1'b0, pp[2][7] & pp[3][6]}
               + {1'b0, pp[2][7] | pp[3][6]};
    assign c10 = pp[3][7];

    assign z = (hi_part << 4)
             + (16'(c7) << 7)
             + (16'(c8) << 8)
             + (16'(c9) << 9)
             + (16'(c10) << 10);

endmodule

// File: rtl/am_mult_share_sched.sv
// Round-robin scheduler sharing one exact/approximate 8x8 multiplier between
// NREQ requesters through a two-stage elastic pipeline with a tagged response.
module am_mult_share_sched
    import am_sched_pkg::*;
#(
    parameter int NREQ = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NREQ-1:0]          req_valid,
    output logic [NREQ-1:0]          req_ready,
    input  logic [8*NREQ-1:0]        req_x,
    input  logic [8*NREQ-1:0]        req_y,
    input  logic [NREQ-1:0]          req_approx,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [$clog2(NREQ)-1:0]  rsp_id,
    output logic [15:0]              rsp_z,
    output logic                     rsp_approx,
    output logic [15:0]              issue_cnt
);

    localparam int IDW = $clog2(NREQ);

    logic [OPW-1:0]   x_arr [NREQ];
    logic [OPW-1:0]   y_arr [NREQ];

    logic             v1_q, v1_d;
    logic             v2_q, v2_d;
    s1_entry_t        s1_q, s1_d;
    s2_entry_t        s2_q, s2_d;
    logic [IDW-1:0]   ptr_q, ptr_d;
    logic [15:0]      issue_cnt_q, issue_cnt_d;

    logic             s2_adv;
    logic             s1_adv;
    logic             found;
    logic [IDW-1:0]   gidx;
    logic [NREQ-1:0]  grant;
    logic             accept;

    logic [PRODW-1:0] z_exact;
    logic [PRODW-1:0] z_approx;
    logic [PRODW-1:0] z_sel;
    logic             id_unused;

    generate
        for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
            assign x_arr[gi] = req_x[gi*OPW +: OPW];
            assign y_arr[gi] = req_y[gi*OPW +: OPW];
        end
    endgenerate

    assign s2_adv = !v2_q | rsp_ready;
    assign s1_adv = !v1_q | s2_adv;

    // First valid requester after the last granted one, wrapping around.
    always_comb begin
        found = 1'b0;
        gidx  = '0;
        grant = '0;
        for (int k = 1; k <= NREQ; k++) begin
            if (!found && req_valid[IDW'(rr_index(int'(ptr_q), k, NREQ))]) begin
                found = 1'b1;
                gidx  = IDW'(rr_index(int'(ptr_q), k, NREQ));
            end
        end
        if (found) begin
            grant[gidx] = 1'b1;
        end
    end

    assign req_ready = (rst_n && s1_adv) ? grant : '0;
    assign accept    = found & s1_adv & rst_n;

    assign z_exact = 16'(s1_q.x) * 16'(s1_q.y);

    am8x8_l4_core u_core (
        .x (s1_q.x),
        .y (s1_q.y),
        .z (z_approx)
    );

    assign z_sel = s1_q.approx ? z_approx : z_exact;

    always_comb begin
        v1_d        = accept | (v1_q & !s2_adv);
        s1_d        = s1_q;
        v2_d        = v2_q;
        s2_d        = s2_q;
        ptr_d       = ptr_q;
        issue_cnt_d = issue_cnt_q + 16'(accept);

        if (accept) begin
            s1_d.id     = IDW_MAX'(gidx);
            s1_d.x      = x_arr[gidx];
            s1_d.y      = y_arr[gidx];
            s1_d.approx = req_approx[gidx];
            ptr_d       = gidx;
        end

        // S2 data only moves when a real entry arrives, so rsp_* stay quiet
        // while the pipe is draining.
        if (s2_adv) begin
            v2_d = v1_q;
            if (v1_q) begin
                s2_d.id     = s1_q.id;
                s2_d.z      = z_sel;
                s2_d.approx = s1_q.approx;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            v1_q        <= 1'b0;
            v2_q        <= 1'b0;
            s1_q        <= '0;
            s2_q        <= '0;
            ptr_q       <= IDW'(NREQ - 1);
            issue_cnt_q <= '0;
        end else begin
            v1_q        <= v1_d;
            v2_q        <= v2_d;
            s1_q        <= s1_d;
            s2_q        <= s2_d;
            ptr_q       <= ptr_d;
            issue_cnt_q <= issue_cnt_d;
        end
    end

    assign rsp_valid  = v2_q;
    assign rsp_id     = s2_q.id[IDW-1:0];
    assign rsp_z      = s2_q.z;
    assign rsp_approx = s2_q.approx;
    assign issue_cnt  = issue_cnt_q;
    assign id_unused  = ^s2_q.id;

endmodule

// File: tb/tb_am_mult_share_sched.sv
// Bench for am_mult_share_sched: per-cycle model check of arbitration, flow
// control and products, plus directed vectors with literal expectations.
module tb_am_mult_share_sched;

    localparam int NREQ = 4;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [NREQ-1:0]   req_valid = '0;
    logic [NREQ-1:0]   req_ready;
    logic [8*NREQ-1:0] req_x = '0;
    logic [8*NREQ-1:0] req_y = '0;
    logic [NREQ-1:0]   req_approx = '0;
    logic              rsp_valid;
    logic              rsp_ready = 1'b1;
    logic [1:0]        rsp_id;
    logic [15:0]       rsp_z;
    logic              rsp_approx;
    logic [15:0]       issue_cnt;

    always #5 clk = ~clk;

    am_mult_share_sched #(.NREQ(NREQ)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_x      (req_x),
        .req_y      (req_y),
        .req_approx (req_approx),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_id     (rsp_id),
        .rsp_z      (rsp_z),
        .rsp_approx (rsp_approx),
        .issue_cnt  (issue_cnt)
    );

    typedef struct {
        int          id;
        logic [15:0] z;
        logic        a;
    } exp_t;

    int          checks = 0;
    int          errors = 0;
    bit          verbose = 1'b1;
    exp_t        exp_q[$];
    int          acc_log[$];
    int          rsp_log[$];
    int          mptr = NREQ - 1;
    logic [15:0] mcnt = '0;
    int          acc_total = 0;
    bit          hold = 1'b0;
    logic [1:0]  prev_id;
    logic [15:0] prev_z;
    logic        prev_a;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] expv);
        checks++;
        if (got !== expv) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", name, got, expv);
        end
    endtask

    function automatic logic [15:0] ref_z(input logic [7:0] x, input logic [7:0] y, input logic a);
        int p [4][8];
        int s;
        if (!a) return 16'(int'(x) * int'(y));
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 8; j++)
                p[i][j] = int'(x[i] & y[j]);
        s = ((int'(y) * int'(x[7:4])) << 4)
          + 128 * ((p[0][6] | p[1][5]) + (p[0][7] | p[1][6]) + (p[2][4] | p[3][3]) + (p[2][5] ^ p[3][4]))
          + 256 * (p[1][7] + (p[2][5] & p[3][4]) + (p[2][6] ^ p[3][5]))
          + 512 * ((p[2][6] & p[3][5]) + (p[2][7] & p[3][6]) + (p[2][7] | p[3][6]))
          + 1024 * p[3][7];
        return 16'(s % 65536);
    endfunction

    // Model check, sampled on the falling edge while inputs are stable.
    always @(negedge clk) begin
        if (!rst_n) begin
            chk("ready_in_reset", 32'(req_ready), 0);
            exp_q.delete();
            mptr = NREQ - 1;
            mcnt = '0;
            hold = 1'b0;
        end else begin
            int              g;
            bit              adv;
            logic [NREQ-1:0] er;
            exp_t            e;
            g = -1;
            for (int k = 1; k <= NREQ; k++) begin
                if (g < 0 && req_valid[(mptr + k) % NREQ]) g = (mptr + k) % NREQ;
            end
            adv = !(exp_q.size() == 2 && !rsp_ready);
            er  = (g >= 0 && adv) ? NREQ'(1 << g) : '0;
            chk("req_ready", 32'(req_ready), 32'(er));
            chk("issue_cnt", 32'(issue_cnt), 32'(mcnt));
            if (exp_q.size() == 0) chk("idle_rsp_valid", 32'(rsp_valid), 0);
            if (exp_q.size() == 2) chk("full_rsp_valid", 32'(rsp_valid), 1);
            if (hold) begin
                chk("stall_valid", 32'(rsp_valid), 1);
                chk("stall_id", 32'(rsp_id), 32'(prev_id));
                chk("stall_z", 32'(rsp_z), 32'(prev_z));
                chk("stall_approx", 32'(rsp_approx), 32'(prev_a));
            end
            if (rsp_valid && rsp_ready) begin
                if (exp_q.size() == 0) begin
                    chk("rsp_unexpected", 32'(rsp_valid), 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("rsp_id", 32'(rsp_id), 32'(e.id));
                    chk("rsp_z", 32'(rsp_z), 32'(e.z));
                    chk("rsp_approx", 32'(rsp_approx), 32'(e.a));
                    rsp_log.push_back(int'(rsp_id));
                    if (verbose)
                        $display("rsp id=%0d z=%0d approx=%0d cnt=%0d", rsp_id, rsp_z, rsp_approx, issue_cnt);
                end
            end
            for (int i = 0; i < NREQ; i++) begin
                if (req_valid[i] && req_ready[i]) begin
                    e.id = i;
                    e.a  = req_approx[i];
                    e.z  = ref_z(req_x[8*i +: 8], req_y[8*i +: 8], req_approx[i]);
                    exp_q.push_back(e);
                    acc_log.push_back(i);
                    mptr = i;
                    mcnt = mcnt + 16'd1;
                    acc_total++;
                end
            end
            hold    = rsp_valid && !rsp_ready;
            prev_id = rsp_id;
            prev_z  = rsp_z;
            prev_a  = rsp_approx;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic v, input logic [7:0] x, input logic [7:0] y, input logic a);
        req_valid[i]    = v;
        req_x[8*i +: 8] = x;
        req_y[8*i +: 8] = y;
        req_approx[i]   = a;
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        req_valid = '0;
        rsp_ready = 1'b1;
        tick(2);
        rst_n = 1'b1;
    endtask

    task automatic single_op(input string name, input int i, input logic [7:0] x, input logic [7:0] y,
                             input logic a, input logic [15:0] expz, input logic [15:0] expcnt);
        set_req(i, 1'b1, x, y, a);
        tick(1);
        req_valid[i] = 1'b0;
        tick(1);
        @(negedge clk);
        chk({name, "_valid"}, 32'(rsp_valid), 1);
        chk({name, "_id"}, 32'(rsp_id), 32'(i));
        chk({name, "_z"}, 32'(rsp_z), 32'(expz));
        chk({name, "_cnt"}, 32'(issue_cnt), 32'(expcnt));
        tick(1);
    endtask

    task automatic random_cycle(input int pct_valid, input int pct_ready);
        for (int i = 0; i < NREQ; i++) begin
            set_req(i, 1'($urandom_range(99) < pct_valid), 8'($urandom), 8'($urandom), 1'($urandom));
        end
        rsp_ready = 1'($urandom_range(99) < pct_ready);
        tick(1);
    endtask

    initial begin
        tick(3);
        rst_n = 1'b1;
        @(negedge clk);
        chk("reset_rsp_valid", 32'(rsp_valid), 0);
        chk("reset_rsp_z", 32'(rsp_z), 0);
        chk("reset_rsp_id", 32'(rsp_id), 0);
        chk("reset_issue_cnt", 32'(issue_cnt), 0);
        tick(1);

        single_op("single_approx", 0, 8'hFF, 8'hFF, 1'b1, 16'd64656, 16'd1);
        single_op("single_exact", 0, 8'hFF, 8'hFF, 1'b0, 16'd65025, 16'd2);
        single_op("approx_hi_nibble", 2, 8'h10, 8'h03, 1'b1, 16'd48, 16'd3);

        // All four requesting continuously from reset
        do_reset();
        acc_log.delete();
        rsp_log.delete();
        for (int i = 0; i < NREQ; i++) set_req(i, 1'b1, 8'(i + 1), 8'd3, 1'b0);
        tick(8);
        req_valid = '0;
        tick(3);
        chk("rr_accepts", 32'(acc_log.size()), 8);
        chk("rr_responses", 32'(rsp_log.size()), 8);
        for (int k = 0; k < 8 && k < acc_log.size() && k < rsp_log.size(); k++) begin
            chk("rr_grant_order", 32'(acc_log[k]), 32'(k % NREQ));
            chk("rr_rsp_order", 32'(rsp_log[k]), 32'(k % NREQ));
        end
        chk("rr_issue_cnt", 32'(issue_cnt), 8);

        // Backpressure with three requesters active
        acc_log.delete();
        rsp_log.delete();
        rsp_ready = 1'b0;
        for (int i = 0; i < 3; i++) set_req(i, 1'b1, 8'hA0 + 8'(i), 8'h5B, 1'(i));
        tick(5);
        chk("bp_ready_zero", 32'(req_ready), 0);
        chk("bp_accepts", 32'(acc_log.size()), 2);
        req_valid = '0;
        rsp_ready = 1'b1;
        tick(3);
        chk("bp_drained", 32'(rsp_log.size()), 2);
        if (rsp_log.size() == 2 && acc_log.size() == 2) begin
            chk("bp_first", 32'(rsp_log[0]), 0);
            chk("bp_second", 32'(rsp_log[1]), 1);
        end

        // Reset with both stages occupied
        rsp_ready = 1'b0;
        set_req(1, 1'b1, 8'h77, 8'h99, 1'b1);
        tick(3);
        for (int i = 0; i < NREQ; i++) set_req(i, 1'b1, 8'(16 * i + 3), 8'h21, 1'b0);
        rst_n = 1'b0;
        tick(1);
        @(negedge clk);
        chk("midrst_rsp_valid", 32'(rsp_valid), 0);
        chk("midrst_issue_cnt", 32'(issue_cnt), 0);
        tick(0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        rsp_ready = 1'b1;
        acc_log.delete();
        tick(1);
        chk("midrst_first_grant", (acc_log.size() > 0) ? 32'(acc_log[0]) : 32'hFFFF_FFFF, 0);
        req_valid = '0;
        tick(3);

        // Random traffic scoreboard
        verbose = 1'b0;
        repeat (3000) random_cycle(60, 70);
        req_valid = '0;
        rsp_ready = 1'b1;
        tick(4);
        chk("random_drained", 32'(exp_q.size()), 0);

        // Counter wrap after 65536 accepts
        do_reset();
        acc_total = 0;
        repeat (65536) random_cycle(100, 100);
        req_valid = '0;
        tick(4);
        chk("wrap_accepts", 32'(acc_total), 65536);
        chk("wrap_issue_cnt", 32'(issue_cnt), 0);
        chk("wrap_drained", 32'(exp_q.size()), 0);
        verbose = 1'b1;
        single_op("post_wrap", 1, 8'h12, 8'h34, 1'b0, 16'd936, 16'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
